miso_pack_fifo: RTL and testbench

MISO_PACK_FIFO -- requirements
Module: miso_pack_fifo

---
 rtl/miso_pack_fifo_if.sv | 42 ++++
 rtl/miso_pack_fifo.sv | 193 +++++++++++++++++++
 tb/tb_miso_pack_fifo.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/miso_pack_fifo_if.sv
// miso_pack_fifo_if: handshake/bus bundle for miso_pack_fifo.
// master = producer/consumer side, slave = FIFO side.
interface miso_pack_fifo_if #(
  parameter int DEPTH       = 32,
  parameter int DATA_WIDTH  = 8,
  parameter int DATA_LENGTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                                   i_clear;
  logic                                   i_r_pointer_reset;
  logic                                   i_write_en;
  logic [DATA_LENGTH-1:0][DATA_WIDTH-1:0] i_data;
  logic [DATA_LENGTH-1:0]                 i_valid;
  logic                                   i_pop_en;
  logic [1:0]                             i_p_mode;
  logic [DATA_WIDTH-1:0]                  o_data;
  logic                                   o_pop_valid;
  logic                                   o_empty;
  logic                                   o_full;
  logic [CW-1:0]                          o_count;
  logic                                   o_write_ready;
  logic                                   o_drop;

  modport master (
    output i_clear, i_r_pointer_reset,
    output i_write_en, i_data, i_valid,
    output i_pop_en, i_p_mode,
    input  o_data, o_pop_valid,
    input  o_empty, o_full, o_count,
    input  o_write_ready, o_drop
  );

  modport slave (
    input  i_clear, i_r_pointer_reset,
    input  i_write_en, i_data, i_valid,
    input  i_pop_en, i_p_mode,
    output o_data, o_pop_valid,
    output o_empty, o_full, o_count,
    output o_write_ready, o_drop
  );
endinterface

// File: rtl/miso_pack_fifo.sv
// miso_pack_fifo: multi-lane compacting writer, precision-packed popper.
// Ports: i_clk, i_nrst (async low), bus (slave: clear, r_pointer_reset,
//   write_en/data/valid, pop_en/p_mode -> data, pop_valid, empty,
//   full, count, write_ready, drop).
// Option: define MISO_FIFO_REPLAY_EN to retain popped entries and allow
//   rewinding the read pointer to the replay mark.
module miso_pack_fifo #(
  parameter int DEPTH       = 32,
  parameter int DATA_WIDTH  = 8,
  parameter int DATA_LENGTH = 8
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  miso_pack_fifo_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int HW = DATA_WIDTH / 2;
  localparam int QW = DATA_WIDTH / 4;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [AW-1:0] idx_t;
  typedef logic [DATA_WIDTH-1:0] word_t;

  word_t mem_q [DEPTH];

  ptr_t  w_ptr_q, w_ptr_d;
  ptr_t  r_ptr_q, r_ptr_d;
  word_t data_q, data_d;
  logic  pop_valid_q, pop_valid_d;
  logic  drop_q, drop_d;

`ifdef MISO_FIFO_REPLAY_EN
  ptr_t  mark_q, mark_d;
`endif

  ptr_t  base;
  ptr_t  occ;
  ptr_t  rd_cnt;
  ptr_t  free;
  ptr_t  v_cnt;
  idx_t  lane_idx [DATA_LENGTH];
  idx_t  r_idx;
  logic  wr_fit;
  logic  wr_acc;
  logic  wr_rej;
  logic  pop;
  logic  mode_half;
  logic  mode_quar;
  logic [2:0] fetch;
  logic [2:0] n_pop;
  word_t pk;

  // Occupancy is measured from the mark when entries are retained,
  // while readability is always measured from the read pointer.
`ifdef MISO_FIFO_REPLAY_EN
  assign base = mark_q;
`else
  assign base = r_ptr_q;
`endif

  assign occ    = w_ptr_q - base;
  assign rd_cnt = w_ptr_q - r_ptr_q;
  assign free   = ptr_t'(DEPTH) - occ;
  assign r_idx  = r_ptr_q[AW-1:0];

  // Compaction: each set lane lands at w_ptr plus the number of
  // set lanes below it; the running total is the write size.
  always_comb begin
    ptr_t acc;
    acc = '0;
    for (int l = 0; l < DATA_LENGTH; l++) begin
      lane_idx[l] = w_ptr_q[AW-1:0] + acc[AW-1:0];
      acc = acc + ptr_t'(bus.i_valid[l]);
    end
    v_cnt = acc;
  end

  assign wr_fit = (v_cnt <= free);
  assign wr_acc = bus.i_write_en & wr_fit & ~bus.i_clear;
  assign wr_rej = bus.i_write_en & ~wr_fit & ~bus.i_clear;

  assign pop = bus.i_pop_en & (rd_cnt != '0)
             & ~bus.i_clear & ~bus.i_r_pointer_reset;

  assign mode_half = (bus.i_p_mode == 2'b01);
  assign mode_quar = (bus.i_p_mode == 2'b10);

  always_comb begin
    fetch = 3'd1;
    unique case (1'b1)
      mode_half: fetch = 3'd2;
      mode_quar: fetch = 3'd4;
      default:   fetch = 3'd1;
    endcase
  end

  assign n_pop = (rd_cnt < ptr_t'(fetch)) ? rd_cnt[2:0] : fetch;

  // Packing: entry r_ptr+j fills slice j with its low bits; slices
  // beyond the readable count stay zero.
  always_comb begin
    pk = '0;
    unique case (1'b1)
      mode_half: begin
        for (int j = 0; j < 2; j++) begin
          if (ptr_t'(j) < rd_cnt)
            pk[j*HW +: HW] = mem_q[r_idx + idx_t'(j)][HW-1:0];
        end
      end
      mode_quar: begin
        for (int j = 0; j < 4; j++) begin
          if (ptr_t'(j) < rd_cnt)
            pk[j*QW +: QW] = mem_q[r_idx + idx_t'(j)][QW-1:0];
        end
      end
      default: pk = mem_q[r_idx];
    endcase
  end

  always_comb begin
    w_ptr_d     = w_ptr_q;
    r_ptr_d     = r_ptr_q;
    data_d      = '0;
    pop_valid_d = 1'b0;
    drop_d      = wr_rej;
`ifdef MISO_FIFO_REPLAY_EN
    mark_d      = mark_q;
`endif
    if (bus.i_clear) begin
      w_ptr_d = '0;
      r_ptr_d = '0;
      drop_d  = 1'b0;
`ifdef MISO_FIFO_REPLAY_EN
      mark_d  = '0;
`endif
    end else begin
      if (wr_acc)
        w_ptr_d = w_ptr_q + v_cnt;
      if (bus.i_r_pointer_reset) begin
`ifdef MISO_FIFO_REPLAY_EN
        r_ptr_d = mark_q;
`endif
      end else if (pop) begin
        r_ptr_d     = r_ptr_q + ptr_t'(n_pop);
        data_d      = pk;
        pop_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      data_q      <= '0;
      pop_valid_q <= 1'b0;
      drop_q      <= 1'b0;
`ifdef MISO_FIFO_REPLAY_EN
      mark_q      <= '0;
`endif
    end else begin
      w_ptr_q     <= w_ptr_d;
      r_ptr_q     <= r_ptr_d;
      data_q      <= data_d;
      pop_valid_q <= pop_valid_d;
      drop_q      <= drop_d;
`ifdef MISO_FIFO_REPLAY_EN
      mark_q      <= mark_d;
`endif
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (wr_acc) begin
      for (int l = 0; l < DATA_LENGTH; l++) begin
        if (bus.i_valid[l])
          mem_q[lane_idx[l]] <= bus.i_data[l];
      end
    end
  end

  assign bus.o_data        = data_q;
  assign bus.o_pop_valid   = pop_valid_q;
  assign bus.o_drop        = drop_q;
  assign bus.o_count       = occ;
  assign bus.o_empty       = (rd_cnt == '0);
  assign bus.o_full        = (occ == ptr_t'(DEPTH));
  assign bus.o_write_ready = (free >= ptr_t'(DATA_LENGTH));

endmodule

// File: tb/tb_miso_pack_fifo.sv
// tb_miso_pack_fifo: directed checks for miso_pack_fifo.
// Drives after the edge, samples 1 time unit after the rising edge.
module tb_miso_pack_fifo;

  localparam int DEPTH = 32;
  localparam int DW    = 8;
  localparam int DL    = 8;

  logic clk = 1'b0;
  logic nrst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  miso_pack_fifo_if #(
    .DEPTH(DEPTH), .DATA_WIDTH(DW), .DATA_LENGTH(DL)
  ) bus ();

  miso_pack_fifo #(
    .DEPTH(DEPTH), .DATA_WIDTH(DW), .DATA_LENGTH(DL)
  ) dut (
    .i_clk (clk),
    .i_nrst(nrst),
    .bus   (bus)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.i_clear           = 1'b0;
    bus.i_r_pointer_reset = 1'b0;
    bus.i_write_en        = 1'b0;
    bus.i_data            = '0;
    bus.i_valid           = '0;
    bus.i_pop_en          = 1'b0;
    bus.i_p_mode          = 2'b00;
  endtask

  task automatic set_wr(input logic [DL-1:0] v,
                        input logic [DL*DW-1:0] d);
    bus.i_write_en = 1'b1;
    bus.i_valid    = v;
    bus.i_data     = d;
  endtask

  task automatic clr_wr;
    bus.i_write_en = 1'b0;
    bus.i_valid    = '0;
    bus.i_data     = '0;
  endtask

  task automatic do_clear;
    idle();
    bus.i_clear = 1'b1;
    step();
    bus.i_clear = 1'b0;
  endtask

  function automatic logic [DL*DW-1:0] seq(input logic [7:0] b);
    logic [DL*DW-1:0] r;
    for (int l = 0; l < DL; l++) r[l*DW +: DW] = b + 8'(l);
    return r;
  endfunction

  task automatic test_reset;
    idle();
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.o_empty, bus.o_full, bus.o_write_ready,
         bus.o_pop_valid, bus.o_drop} !== 5'b10100) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 10100",
        {bus.o_empty, bus.o_full, bus.o_write_ready,
         bus.o_pop_valid, bus.o_drop});
    end
    n_cmp++;
    if (bus.o_count !== 6'd0) begin
      n_bad++;
      $display("FAIL reset_count: got %0d want 0", bus.o_count);
    end
    n_cmp++;
    if (bus.o_data !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_data: got %h want 00", bus.o_data);
    end
    nrst = 1'b1;
    step();
  endtask

  task automatic test_compact;
    logic [7:0] exp4 [4];
    exp4 = '{8'd11, 8'd22, 8'd33, 8'd44};
    do_clear();
    set_wr(8'b1010_0101, {8'd44, 8'd0, 8'd33, 8'd0,
                          8'd0, 8'd22, 8'd0, 8'd11});
    step();
    clr_wr();
    n_cmp++;
    if (bus.o_count !== 6'd4) begin
      n_bad++;
      $display("FAIL compact_count: got %0d want 4", bus.o_count);
    end
    bus.i_pop_en = 1'b1;
    bus.i_p_mode = 2'b00;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if ({bus.o_pop_valid, bus.o_data} !== {1'b1, exp4[i]}) begin
        n_bad++;
        $display("FAIL compact_pop%0d: got v=%b d=%0d want v=1 d=%0d",
          i, bus.o_pop_valid, bus.o_data, exp4[i]);
      end
    end
    n_cmp++;
    if ({bus.o_empty, bus.o_count} !== {1'b1, 6'd0}) begin
      n_bad++;
      $display("FAIL compact_empty: got e=%b c=%0d want e=1 c=0",
        bus.o_empty, bus.o_count);
    end
    step();
    n_cmp++;
    if ({bus.o_pop_valid, bus.o_data} !== 9'd0) begin
      n_bad++;
      $display("FAIL empty_pop: got v=%b d=%h want v=0 d=00",
        bus.o_pop_valid, bus.o_data);
    end
    idle();
  endtask

  task automatic test_half;
    do_clear();
    set_wr(8'b0000_0111, {40'd0, 8'hC3, 8'hB2, 8'hA1});
    step();
    clr_wr();
    bus.i_pop_en = 1'b1;
    bus.i_p_mode = 2'b01;
    step();
    n_cmp++;
    if ({bus.o_pop_valid, bus.o_data, bus.o_count}
        !== {1'b1, 8'h21, 6'd1}) begin
      n_bad++;
      $display("FAIL half_pop0: got v=%b d=%h c=%0d want v=1 d=21 c=1",
        bus.o_pop_valid, bus.o_data, bus.o_count);
    end
    step();
    n_cmp++;
    if ({bus.o_pop_valid, bus.o_data, bus.o_empty}
        !== {1'b1, 8'h03, 1'b1}) begin
      n_bad++;
      $display("FAIL half_pop1: got v=%b d=%h e=%b want v=1 d=03 e=1",
        bus.o_pop_valid, bus.o_data, bus.o_empty);
    end
    idle();
  endtask

  task automatic test_quarter;
    do_clear();
    set_wr(8'b0001_1111, {24'd0, 8'h03, 8'h00, 8'h03, 8'h02, 8'h01});
    step();
    clr_wr();
    bus.i_pop_en = 1'b1;
    bus.i_p_mode = 2'b10;
    step();
    n_cmp++;
    if ({bus.o_pop_valid, bus.o_data} !== {1'b1, 8'h39}) begin
      n_bad++;
      $display("FAIL quarter_pop0: got v=%b d=%h want v=1 d=39",
        bus.o_pop_valid, bus.o_data);
    end
    step();
    n_cmp++;
    if ({bus.o_pop_valid, bus.o_data, bus.o_empty}
        !== {1'b1, 8'h03, 1'b1}) begin
      n_bad++;
      $display("FAIL quarter_pop1: got v=%b d=%h e=%b want v=1 d=03 e=1",
        bus.o_pop_valid, bus.o_data, bus.o_empty);
    end
    idle();
  endtask

  task automatic test_mode11;
    do_clear();
    set_wr(8'b0000_0011, {48'd0, 8'h3C, 8'hF5});
    step();
    clr_wr();
    bus.i_pop_en = 1'b1;
    bus.i_p_mode = 2'b11;
    step();
    n_cmp++;
    if ({bus.o_pop_valid, bus.o_data, bus.o_count}
        !== {1'b1, 8'hF5, 6'd1}) begin
      n_bad++;
      $display("FAIL mode11_pop: got v=%b d=%h c=%0d want v=1 d=f5 c=1",
        bus.o_pop_valid, bus.o_data, bus.o_count);
    end
    bus.i_pop_en = 1'b0;
    bus.i_p_mode = 2'b10;
    step();
    n_cmp++;
    if ({bus.o_pop_valid, bus.o_data, bus.o_count}
        !== {1'b0, 8'h00, 6'd1}) begin
      n_bad++;
      $display("FAIL no_pop: got v=%b d=%h c=%0d want v=0 d=00 c=1",
        bus.o_pop_valid, bus.o_data, bus.o_count);
    end
    bus.i_pop_en = 1'b1;
    bus.i_p_mode = 2'b01;
    step();
    n_cmp++;
    if ({bus.o_pop_valid, bus.o_data, bus.o_empty}
        !== {1'b1, 8'h0C, 1'b1}) begin
      n_bad++;
      $display("FAIL half_short: got v=%b d=%h e=%b want v=1 d=0c e=1",
        bus.o_pop_valid, bus.o_data, bus.o_empty);
    end
    idle();
  endtask

  task automatic test_overflow;
    do_clear();
    for (int k = 0; k < 3; k++) begin
      set_wr(8'hFF, seq(8'(8'h10 + 8 * k)));
      step();
    end
    set_wr(8'h3F, seq(8'h28));
    step();
    clr_wr();
    n_cmp++;
    if ({bus.o_count, bus.o_write_ready, bus.o_full}
        !== {6'd30, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL fill30: got c=%0d wr=%b f=%b want c=30 wr=0 f=0",
        bus.o_count, bus.o_write_ready, bus.o_full);
    end
    set_wr(8'hFF, seq(8'h80));
    step();
    clr_wr();
    n_cmp++;
    if ({bus.o_drop, bus.o_count} !== {1'b1, 6'd30}) begin
      n_bad++;
      $display("FAIL drop_reject: got drop=%b c=%0d want drop=1 c=30",
        bus.o_drop, bus.o_count);
    end
    step();
    n_cmp++;
    if (bus.o_drop !== 1'b0) begin
      n_bad++;
      $display("FAIL drop_pulse: got %b want 0", bus.o_drop);
    end
    set_wr(8'h03, seq(8'h2E));
    step();
    clr_wr();
    n_cmp++;
    if ({bus.o_count, bus.o_full, bus.o_drop}
        !== {6'd32, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL fill_full: got c=%0d f=%b drop=%b want c=32 f=1 drop=0",
        bus.o_count, bus.o_full, bus.o_drop);
    end
    set_wr(8'hFF, seq(8'h90));
    bus.i_pop_en = 1'b1;
    bus.i_p_mode = 2'b00;
    step();
    clr_wr();
    bus.i_pop_en = 1'b0;
    n_cmp++;
    if ({bus.o_drop, bus.o_count, bus.o_pop_valid, bus.o_data}
        !== {1'b1, 6'd31, 1'b1, 8'h10}) begin
      n_bad++;
      $display("FAIL full_wr_pop: got drop=%b c=%0d v=%b d=%h want 1 31 1 10",
        bus.o_drop, bus.o_count, bus.o_pop_valid, bus.o_data);
    end
    set_wr(8'h01, seq(8'hA0));
    bus.i_pop_en = 1'b1;
    bus.i_clear  = 1'b1;
    step();
    idle();
    n_cmp++;
    if ({bus.o_count, bus.o_empty, bus.o_pop_valid, bus.o_data, bus.o_drop}
        !== {6'd0, 1'b1, 1'b0, 8'h00, 1'b0}) begin
      n_bad++;
      $display("FAIL clear: got c=%0d e=%b v=%b d=%h drop=%b want 0 1 0 00 0",
        bus.o_count, bus.o_empty, bus.o_pop_valid, bus.o_data, bus.o_drop);
    end
  endtask

  task automatic test_wrap;
    logic [7:0] q[$];
    logic [DL*DW-1:0] d;
    logic [16:0] got, want;
    logic [7:0] expd;
    int pre, cnt;
    logic acc, popped;
    do_clear();
    bus.i_pop_en = 1'b1;
    bus.i_p_mode = 2'b00;
    for (int c = 0; c < 20; c++) begin
      d = seq(8'(c * 8));
      set_wr(8'hFF, d);
      pre    = q.size();
      acc    = (DL <= DEPTH - pre);
      popped = (pre > 0);
      expd   = popped ? q[0] : 8'h00;
      cnt    = pre + (acc ? DL : 0) - (popped ? 1 : 0);
      step();
      got  = {bus.o_pop_valid, bus.o_data, bus.o_full,
              bus.o_drop, bus.o_count};
      want = {popped, expd, (cnt == DEPTH), !acc, 6'(cnt)};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL wrap_c%0d: got %h want %h", c, got, want);
      end
      if (popped) void'(q.pop_front());
      if (acc)
        for (int l = 0; l < DL; l++) q.push_back(d[l*DW +: DW]);
    end
    clr_wr();
    for (int c = 0; c < 40; c++) begin
      if (q.size() == 0) break;
      expd = q.pop_front();
      step();
      n_cmp++;
      if ({bus.o_pop_valid, bus.o_data} !== {1'b1, expd}) begin
        n_bad++;
        $display("FAIL drain_c%0d: got v=%b d=%h want v=1 d=%h",
          c, bus.o_pop_valid, bus.o_data, expd);
      end
    end
    n_cmp++;
    if ({bus.o_empty, q.size() == 0} !== 2'b11) begin
      n_bad++;
      $display("FAIL drain_end: got e=%b left=%0d want e=1 left=0",
        bus.o_empty, q.size());
    end
    idle();
  endtask

  task automatic test_replay;
    logic [7:0] exp4 [4];
    exp4 = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
    do_clear();
    set_wr(8'h0F, {32'd0, 8'h8D, 8'h7C, 8'h6B, 8'h5A});
    step();
    clr_wr();
    bus.i_pop_en = 1'b1;
    bus.i_p_mode = 2'b00;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if ({bus.o_pop_valid, bus.o_data} !== {1'b1, exp4[i]}) begin
        n_bad++;
        $display("FAIL replay_first%0d: got v=%b d=%h want v=1 d=%h",
          i, bus.o_pop_valid, bus.o_data, exp4[i]);
      end
    end
    bus.i_r_pointer_reset = 1'b1;
    step();
    bus.i_r_pointer_reset = 1'b0;
    n_cmp++;
    if ({bus.o_pop_valid, bus.o_data} !== 9'd0) begin
      n_bad++;
      $display("FAIL rptr_reset_out: got v=%b d=%h want v=0 d=00",
        bus.o_pop_valid, bus.o_data);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
`ifdef MISO_FIFO_REPLAY_EN
      if ({bus.o_pop_valid, bus.o_data, bus.o_count}
          !== {1'b1, exp4[i], 6'd4}) begin
        n_bad++;
        $display("FAIL replay_again%0d: got v=%b d=%h c=%0d want 1 %h 4",
          i, bus.o_pop_valid, bus.o_data, bus.o_count, exp4[i]);
      end
`else
      if ({bus.o_pop_valid, bus.o_empty, bus.o_count}
          !== {1'b0, 1'b1, 6'd0}) begin
        n_bad++;
        $display("FAIL no_replay%0d: got v=%b e=%b c=%0d want 0 1 0",
          i, bus.o_pop_valid, bus.o_empty, bus.o_count);
      end
`endif
    end
    idle();
  endtask

  initial begin
    idle();
    nrst = 1'b1;
    #2;
    test_reset();
`ifdef MISO_FIFO_REPLAY_EN
    test_replay();
`else
    test_compact();
    test_half();
    test_quarter();
    test_mode11();
    test_overflow();
    test_wrap();
    test_replay();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_bad);
    $finish;
  end

endmodule
